// File: rtl/vga_framebuffer_pkg.sv
// vga_framebuffer_pkg: shared clog2, FSM encodings and default visible area
package vga_framebuffer_pkg;
  localparam int DefHVisibleArea = 640;
  localparam int DefVVisibleArea = 480;
  typedef enum logic {FB_IDLE = 1'b0, FB_CLEAR = 1'b1} fb_state_e;
  function automatic int clog2(input int n);
    int r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/vga_framebuffer_bank.sv
// vga_framebuffer_bank: Depth x 3-bit RAM, one synchronous write port and one registered read port
module vga_framebuffer_bank #(
  parameter int Depth = 307200,
  parameter int IdxSize = 19
) (
  input  logic               clock,
  input  logic               we,
  input  logic [IdxSize-1:0] waddr,
  input  logic [2:0]         wdata,
  input  logic [IdxSize-1:0] raddr,
  output logic [2:0]         rdata
);
  logic [2:0] mem [Depth];
  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end
endmodule

// File: rtl/vga_framebuffer.sv
// vga_framebuffer: pixel store with write handshake and clear engine; VGA_FRAMEBUFFER_DOUBLE_EN adds a second bank swapped at frame sync
module vga_framebuffer
  import vga_framebuffer_pkg::*;
#(
  parameter int HAddrSize = 11,
  parameter int VAddrSize = 11,
  parameter int HVisibleArea = DefHVisibleArea,
  parameter int VVisibleArea = DefVVisibleArea
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [HAddrSize-1:0] fb_addr_h,
  input  logic [VAddrSize-1:0] fb_addr_v,
  input  logic                 frame_sync,
  output logic                 color_r,
  output logic                 color_g,
  output logic                 color_b,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  input  logic [HAddrSize-1:0] wr_h,
  input  logic [VAddrSize-1:0] wr_v,
  input  logic                 wr_r,
  input  logic                 wr_g,
  input  logic                 wr_b,
  input  logic                 clear_req,
  output logic                 busy,
  input  logic                 swap_req,
  output logic                 swap_pending
);
  localparam int Pixels = HVisibleArea * VVisibleArea;
  localparam int IdxSize = clog2(Pixels);
  localparam logic [IdxSize-1:0] LastIdx = IdxSize'(Pixels - 1);
`ifdef VGA_FRAMEBUFFER_DOUBLE_EN
  localparam int Banks = 2;
`else
  localparam int Banks = 1;
`endif
  function automatic logic in_range(input logic [HAddrSize-1:0] h, input logic [VAddrSize-1:0] v);
    return (32'(h) < HVisibleArea) && (32'(v) < VVisibleArea);
  endfunction
  function automatic logic [IdxSize-1:0] to_idx(input logic [HAddrSize-1:0] h, input logic [VAddrSize-1:0] v);
    return in_range(h, v) ? IdxSize'(32'(v) * HVisibleArea + 32'(h)) : '0;
  endfunction
  fb_state_e state, state_n;
  logic [IdxSize-1:0] cnt;
  logic clearing, wr_fire, rd_ok;
  logic [Banks-1:0] tgt_clr, tgt_wr;
  logic [2:0] rd_data [Banks];
  logic [2:0] pix;
  assign clearing = state == FB_CLEAR;
  assign wr_ready = ~reset & ~clearing;
  assign busy = reset | clearing;
  assign wr_fire = wr_valid & wr_ready & in_range(wr_h, wr_v);
  always_comb begin
    state_n = clearing ? (cnt == LastIdx ? FB_IDLE : FB_CLEAR) : (clear_req ? FB_CLEAR : FB_IDLE);
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= FB_CLEAR;
      cnt <= '0;
    end else begin
      state <= state_n;
      cnt <= clearing ? cnt + 1'b1 : '0;
    end
    rd_ok <= ~reset & in_range(fb_addr_h, fb_addr_v);
  end
  for (genvar b = 0; b < Banks; b++) begin : g_bank
    vga_framebuffer_bank #(.Depth(Pixels), .IdxSize(IdxSize)) u_bank (
      .clock(clock),
      .we(clearing ? tgt_clr[b] : wr_fire & tgt_wr[b]),
      .waddr(clearing ? cnt : to_idx(wr_h, wr_v)),
      .wdata(clearing ? 3'b000 : {wr_r, wr_g, wr_b}),
      .raddr(to_idx(fb_addr_h, fb_addr_v)),
      .rdata(rd_data[b])
    );
  end
`ifdef VGA_FRAMEBUFFER_DOUBLE_EN
  logic sel, rd_sel, fs_q, pend, clr_all, clr_bank, fs_rise;
  assign fs_rise = frame_sync & ~fs_q;
  assign tgt_wr = sel ? 2'b01 : 2'b10;
  assign tgt_clr = clr_all ? 2'b11 : (clr_bank ? 2'b10 : 2'b01);
  assign pix = rd_data[rd_sel];
  assign swap_pending = pend;
  always_ff @(posedge clock) begin
    if (reset) begin
      sel <= 1'b0;
      rd_sel <= 1'b0;
      fs_q <= 1'b0;
      pend <= 1'b0;
      clr_all <= 1'b1;
      clr_bank <= 1'b0;
    end else begin
      fs_q <= frame_sync;
      rd_sel <= sel;
      sel <= (fs_rise & (pend | swap_req)) ? ~sel : sel;
      pend <= (fs_rise & (pend | swap_req)) ? 1'b0 : (pend | swap_req);
      clr_all <= (~clearing & clear_req) ? 1'b0 : clr_all;
      clr_bank <= (~clearing & clear_req) ? ~sel : clr_bank;
    end
  end
`else
  logic unused_inputs;
  assign unused_inputs = swap_req ^ frame_sync;
  assign tgt_wr = 1'b1;
  assign tgt_clr = 1'b1;
  assign pix = rd_data[0];
  assign swap_pending = 1'b0;
`endif
  assign {color_r, color_g, color_b} = rd_ok ? pix : 3'b000;
endmodule

// File: tb/tb_vga_framebuffer.sv
// tb_vga_framebuffer: scoreboard bench for vga_framebuffer at a 4x5 visible area
module tb_vga_framebuffer;
  localparam int H = 4, V = 5, P = H * V;
  logic clock = 1'b0, reset = 1'b1;
  logic [10:0] fb_addr_h = '0, fb_addr_v = '0, wr_h = '0, wr_v = '0;
  logic frame_sync = 1'b0, wr_valid = 1'b0, wr_r = 1'b0, wr_g = 1'b0, wr_b = 1'b0;
  logic clear_req = 1'b0, swap_req = 1'b0;
  logic color_r, color_g, color_b, wr_ready, busy, swap_pending;
  logic rd_req = 1'b0, rd_pend = 1'b0;
  logic [2:0] model [P];
  logic [2:0] exp_q [$];
  string name_q [$];
  int checks = 0, failures = 0;
  always #5 clock = ~clock;
  vga_framebuffer #(.HVisibleArea(H), .VVisibleArea(V)) dut (
    .clock(clock), .reset(reset), .fb_addr_h(fb_addr_h), .fb_addr_v(fb_addr_v),
    .frame_sync(frame_sync), .color_r(color_r), .color_g(color_g), .color_b(color_b),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_h(wr_h), .wr_v(wr_v),
    .wr_r(wr_r), .wr_g(wr_g), .wr_b(wr_b), .clear_req(clear_req), .busy(busy),
    .swap_req(swap_req), .swap_pending(swap_pending)
  );
  always @(posedge clock) rd_pend <= rd_req;
  always @(negedge clock) begin
    logic [2:0] e;
    string n;
    if (rd_pend) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL scoreboard: read returned %b with no expectation queued", {color_r, color_g, color_b});
      end else begin
        e = exp_q.pop_front();
        n = name_q.pop_front();
        if ({color_r, color_g, color_b} !== e) begin
          failures++;
          $display("FAIL %s: color got %b want %b", n, {color_r, color_g, color_b}, e);
        end
      end
    end
  end
  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %0d want %0d", n, got, want);
    end
  endtask
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  task automatic scan(input int h, input int v, input logic [2:0] e, input string n);
    fb_addr_h = 11'(h);
    fb_addr_v = 11'(v);
    rd_req = 1'b1;
    exp_q.push_back(e);
    name_q.push_back(n);
    tick();
    rd_req = 1'b0;
  endtask
  task automatic write(input int h, input int v, input logic [2:0] c, input logic clr);
    chk("wr_ready_before_write", 32'(wr_ready), 1);
    wr_h = 11'(h);
    wr_v = 11'(v);
    {wr_r, wr_g, wr_b} = c;
    wr_valid = 1'b1;
    clear_req = clr;
    tick();
    wr_valid = 1'b0;
    clear_req = 1'b0;
    if (h < H && v < V) model[v * H + h] = c;
  endtask
  task automatic scan_all(input string n);
    for (int v = 0; v < V; v++)
      for (int h = 0; h < H; h++) scan(h, v, model[v * H + h], n);
  endtask
  task automatic wait_clear(input int pulse_at);
    int n = 0;
    while (busy && n < 100) begin
      clear_req = (n == pulse_at);
      tick();
      n++;
    end
    clear_req = 1'b0;
    chk("busy_cycles", n, P);
    chk("wr_ready_after_clear", 32'(wr_ready), 1);
    for (int i = 0; i < P; i++) model[i] = 3'b000;
  endtask
  task automatic chk_reset_outputs();
    chk("reset_busy", 32'(busy), 1);
    chk("reset_wr_ready", 32'(wr_ready), 0);
    chk("reset_color", 32'({color_r, color_g, color_b}), 0);
    chk("reset_swap_pending", 32'(swap_pending), 0);
  endtask
  initial begin
    for (int i = 0; i < P; i++) model[i] = 3'b000;
    repeat (3) tick();
    chk_reset_outputs();
    reset = 1'b0;
    wait_clear(-1);
    scan_all("post_reset_zero");
`ifdef VGA_FRAMEBUFFER_DOUBLE_EN
    write(0, 0, 3'b100, 1'b0);
    scan(0, 0, 3'b000, "db_hidden_write");
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    chk("db_pending_set", 32'(swap_pending), 1);
    frame_sync = 1'b1;
    tick();
    chk("db_pending_cleared", 32'(swap_pending), 0);
    scan(0, 0, 3'b100, "db_swapped_visible");
    frame_sync = 1'b0;
    tick();
    write(1, 0, 3'b010, 1'b0);
    swap_req = 1'b1;
    frame_sync = 1'b1;
    tick();
    swap_req = 1'b0;
    chk("db_coincident_pending", 32'(swap_pending), 0);
    scan(1, 0, 3'b010, "db_coincident_swap");
    scan(0, 0, 3'b000, "db_other_bank");
`else
    write(2, 3, 3'b110, 1'b0);
    scan(2, 3, 3'b110, "write_readback");
    scan(4, 0, 3'b000, "scan_out_of_range_h");
    scan(0, 5, 3'b000, "scan_out_of_range_v");
    write(5, 1, 3'b111, 1'b0);
    scan_all("after_oob_write");
    wr_h = 11'd3;
    wr_v = 11'd4;
    {wr_r, wr_g, wr_b} = 3'b101;
    wr_valid = 1'b1;
    scan(3, 4, 3'b000, "read_during_write_old");
    wr_valid = 1'b0;
    model[19] = 3'b101;
    scan(3, 4, 3'b101, "read_after_write_new");
    write(1, 1, 3'b001, 1'b1);
    chk("clear_started", 32'(busy), 1);
    wait_clear(5);
    scan(1, 1, 3'b000, "cleared_coincident_write");
    scan(3, 4, 3'b000, "cleared_last_index");
    write(0, 0, 3'b111, 1'b0);
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    repeat (10) tick();
    reset = 1'b1;
    tick();
    chk_reset_outputs();
    reset = 1'b0;
    wait_clear(-1);
    scan_all("after_reset_restart");
`endif
    repeat (2) tick();
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
